iter_alu: RTL and testbench
===========================

ITER_ALU -- requirements
Module: iter_alu

Interface
REQ-001 Parameter XLEN, default 32, datapath width; SHALL be a power of two of at least 8.
REQ-002 Port clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 Port rst  input  1  reset; synchronous, active-high.
REQ-004 Port start  input  1  request to execute one operation.
REQ-005 Port ALU_sel  input  4  operation select; uses the team ALU_* encodings (ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU, PASS).
REQ-006 Port a  input  XLEN  operand A (rs1).
REQ-007 Port b  input  XLEN  operand B (rs2 or immediate); b[log2(XLEN)-1:0] is the shift amount.
REQ-008 Port busy  output  1  high while an iterative shift is in progress.
REQ-009 Port done  output  1  one-cycle pulse; result and flags valid.
REQ-010 Port result  output  XLEN  registered operation result.
REQ-011 Port zf, cf, vf, sf  output  1 each  zero, carry, overflow, sign flags.

Function
REQ-012 The block SHALL accept a request when start=1 and busy=0 at a rising edge; a, b, and ALU_sel SHALL be captured at acceptance and later input changes ignored.
REQ-013 start while busy=1 SHALL be ignored, with no queuing.
REQ-014 States SHALL be IDLE, SHIFT, FIN; busy=1 only in SHIFT.
REQ-015 Non-shift ops and shifts with shamt=0 SHALL go IDLE->FIN; done=1 in the cycle after acceptance (latency 1).
REQ-016 Shifts with shamt=n>0 SHALL go IDLE->SHIFT, load the operand and a counter of n, shift 1 bit per cycle for n cycles, then go to FIN; done=1 in cycle n+1 after acceptance.
REQ-017 FIN SHALL last exactly one cycle, with done=1 and busy=0; a start in FIN SHALL be accepted (back-to-back), otherwise FIN->IDLE.
REQ-018 result and flags SHALL hold their last values until the next completion; only done marks freshness.
REQ-019 ADD/SUB SHALL compute a+b / a-b modulo 2^XLEN; cf SHALL be the carry-out for ADD and the inverted borrow for SUB (cf=1 when a>=b unsigned); vf SHALL be the signed overflow.
REQ-020 AND/OR/XOR SHALL be bitwise; SLT/SLTU SHALL give 1 or 0, zero-extended, for a<b signed/unsigned; PASS SHALL give result=b.
REQ-021 SLL/SRL SHALL fill with 0; SRA SHALL replicate a[XLEN-1] on each step.
REQ-022 zf SHALL equal (result==0) and sf SHALL equal result[XLEN-1] for every op; cf=vf=0 for all ops except ADD/SUB.
REQ-023 An undefined ALU_sel SHALL complete in 1 cycle with result=0, zf=1, and the other flags 0.

Reset
REQ-024 With rst=1 at an edge: state=IDLE, busy=0, done=0, result=0, zf=cf=vf=sf=0, and the counter cleared.
REQ-025 rst SHALL take priority over start and over any in-progress shift; an aborted shift SHALL never produce done.
REQ-026 Requests SHALL be acceptable on the first edge after rst deasserts.

Verification
REQ-027 ADD a=0xFFFFFFFF, b=0x00000001 -> done 1 cycle later; result=0, zf=1, cf=1, vf=0.
REQ-028 SUB a=0x80000000, b=1 -> result=0x7FFFFFFF, vf=1, cf=1, sf=0.
REQ-029 SRA a=0x80000000, b=31 -> busy for 31 cycles, done in cycle 32; result=0xFFFFFFFF, sf=1.
REQ-030 SLL a=1, b=5, with start held high and a changed mid-shift -> result=0x20 at cycle 6; extra starts ignored.
REQ-031 SRL a=0xF0, b=4, with rst pulsed at cycle 2 -> no done, all outputs 0; a new SLTU a=1, b=2 after reset -> result=1.
REQ-032 AND then OR issued on consecutive accepts, the second in the FIN cycle -> two done pulses in adjacent cycles with correct results.

Source files
------------

// File: rtl/iter_alu.sv
// iter_alu: single-issue ALU whose shifts iterate one bit per cycle; other ops complete in one cycle.
module iter_alu #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [3:0]      ALU_sel,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            zf,
  output logic            cf,
  output logic            vf,
  output logic            sf
);
  localparam int SW = $clog2(XLEN);
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;
  localparam logic [3:0] ALU_PASS = 4'd10;

  typedef enum logic [1:0] {IDLE, SHIFT, FIN} state_t;

  state_t          state;
  logic [XLEN-1:0] sh, sh_nxt, alu_r, b_op;
  logic [XLEN:0]   sum;
  logic [SW-1:0]   cnt, shamt;
  logic [3:0]      op;
  logic            is_sub, arith, is_shift, alu_cf, alu_vf;

  always_comb begin
    shamt    = b[SW-1:0];
    is_sub   = ALU_sel == ALU_SUB;
    arith    = ALU_sel == ALU_ADD || is_sub;
    is_shift = ALU_sel inside {ALU_SLL, ALU_SRL, ALU_SRA};
    b_op     = is_sub ? ~b : b;
    sum      = {1'b0, a} + {1'b0, b_op} + {{XLEN{1'b0}}, is_sub};
    alu_cf   = arith & sum[XLEN];
    alu_vf   = arith & (a[XLEN-1] == b_op[XLEN-1]) & (sum[XLEN-1] != a[XLEN-1]);
    alu_r    = arith                ? sum[XLEN-1:0] :
               ALU_sel == ALU_AND   ? a & b :
               ALU_sel == ALU_OR    ? a | b :
               ALU_sel == ALU_XOR   ? a ^ b :
               is_shift             ? a :
               ALU_sel == ALU_SLT   ? {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)} :
               ALU_sel == ALU_SLTU  ? {{(XLEN-1){1'b0}}, a < b} :
               ALU_sel == ALU_PASS  ? b : '0;
    sh_nxt   = op == ALU_SLL ? sh << 1 :
               op == ALU_SRL ? sh >> 1 : {sh[XLEN-1], sh[XLEN-1:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      {zf, cf, vf, sf} <= 4'b0;
      cnt    <= '0;
      sh     <= '0;
      op     <= '0;
    end else if (state == SHIFT) begin
      sh  <= sh_nxt;
      cnt <= cnt - 1'b1;
      if (cnt == SW'(1)) begin
        state  <= FIN;
        busy   <= 1'b0;
        done   <= 1'b1;
        result <= sh_nxt;
        {zf, cf, vf, sf} <= {sh_nxt == '0, 2'b00, sh_nxt[XLEN-1]};
      end
    end else if (start) begin
      if (is_shift && shamt != '0) begin
        state <= SHIFT;
        busy  <= 1'b1;
        done  <= 1'b0;
        sh    <= a;
        cnt   <= shamt;
        op    <= ALU_sel;
      end else begin
        state  <= FIN;
        done   <= 1'b1;
        result <= alu_r;
        {zf, cf, vf, sf} <= {alu_r == '0, alu_cf, alu_vf, alu_r[XLEN-1]};
      end
    end else begin
      state <= IDLE;
      done  <= 1'b0;
    end
  end
endmodule

// File: tb/tb_iter_alu.sv
// tb_iter_alu: randomized and directed scoreboard bench for iter_alu against an arithmetic reference model.
module tb_iter_alu;
  localparam logic [3:0] ADD = 0, SUB = 1, AND_ = 2, OR_ = 3, XOR_ = 4, SLL = 5, SRL = 6,
                         SRA = 7, SLT = 8, SLTU = 9, PASS = 10;

  logic        clk = 0, rst = 1, start = 0;
  logic [3:0]  alu_sel = 0;
  logic [31:0] a = 0, b = 0;
  logic        busy, done, zf, cf, vf, sf;
  logic [31:0] result;

  int total = 0, bad = 0, cyc = 0, brun = 0;

  typedef struct {
    logic [31:0] r;
    logic [3:0]  f;
    int          due;
    int          nb;
  } exp_t;
  exp_t q[$];

  iter_alu #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .ALU_sel(alu_sel), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .zf(zf), .cf(cf), .vf(vf), .sf(sf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h (cycle %0d)", nm, got, want, cyc);
    end
  endtask

  function automatic exp_t model(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
    exp_t   e;
    longint s;
    logic   c, v;
    int     n;
    n = int'(y[4:0]);
    c = 0;
    v = 0;
    case (op)
      ADD: begin
        e.r = x + y;
        c = (longint'(x) + longint'(y)) > 64'sh0_FFFF_FFFF;
        s = longint'($signed(x)) + longint'($signed(y));
        v = s > 64'sd2147483647 || s < -64'sd2147483648;
      end
      SUB: begin
        e.r = x - y;
        c = x >= y;
        s = longint'($signed(x)) - longint'($signed(y));
        v = s > 64'sd2147483647 || s < -64'sd2147483648;
      end
      AND_: e.r = x & y;
      OR_:  e.r = x | y;
      XOR_: e.r = x ^ y;
      SLL:  e.r = x << n;
      SRL:  e.r = x >> n;
      SRA:  e.r = $signed(x) >>> n;
      SLT:  e.r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      SLTU: e.r = (x < y) ? 32'd1 : 32'd0;
      PASS: e.r = y;
      default: e.r = 0;
    endcase
    e.f  = {e.r == 0, c, v, e.r[31]};
    e.nb = (op inside {SLL, SRL, SRA}) ? n : 0;
    e.due = 0;
    return e;
  endfunction

  // Drive at a negedge once the DUT is idle; acceptance happens at the next posedge.
  task automatic issue(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    int   w = 0;
    while (busy && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (w >= 200) chk("issue_wait_timeout", 32'd1, 32'd0);
    alu_sel = op;
    a = x;
    b = y;
    start = 1;
    e = model(op, x, y);
    e.due = cyc + 1 + e.nb;
    q.push_back(e);
    @(negedge clk);
    start = 0;
    a = $urandom;
    b = $urandom;
    alu_sel = 4'($urandom);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst) brun = 0;
    else begin
      if (busy) brun++;
      if (done) begin
        if (q.size() == 0) chk("spurious_done", 32'd1, 32'd0);
        else begin
          e = q.pop_front();
          chk("result", result, e.r);
          chk("flags_zcvs", {28'd0, zf, cf, vf, sf}, {28'd0, e.f});
          chk("done_cycle", cyc, e.due);
          chk("busy_cycles", brun, e.nb);
          chk("busy_at_done", {31'd0, busy}, 32'd0);
        end
        brun = 0;
      end
    end
  end

  task automatic check_zero(input string nm);
    chk({nm, "_result"}, result, 32'd0);
    chk({nm, "_ctl_flags"}, {26'd0, busy, done, zf, cf, vf, sf}, 32'd0);
  endtask

  initial begin
    exp_t e;
    int   w;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 0;
    issue(ADD, 32'hFFFF_FFFF, 32'h1);
    issue(SUB, 32'h8000_0000, 32'h1);
    issue(SRA, 32'h8000_0000, 32'd31);
    // Hold start through the shift with a new operand; it must not be taken.
    issue(SLL, 32'h1, 32'd5);
    start = 1;
    alu_sel = SLL;
    a = 32'hFFFF_0000;
    repeat (3) @(negedge clk);
    start = 0;
    issue(SRL, 32'h0000_00F0, 32'd4);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    q.delete();
    check_zero("abort");
    rst = 0;
    repeat (8) @(negedge clk);
    check_zero("post_abort");
    issue(SLTU, 32'h1, 32'h2);
    repeat (2) @(negedge clk);
    issue(AND_, 32'hF0F0_1234, 32'h0FF0_FF00);
    issue(OR_, 32'hF0F0_1234, 32'h0FF0_FF00);
    issue(4'hF, 32'h1234_5678, 32'h1);
    issue(SRL, 32'hDEAD_BEEF, 32'h20);
    issue(SLT, 32'hFFFF_FFFF, 32'h1);
    for (int i = 0; i < 250; i++) begin
      logic [31:0] x, y;
      x = $urandom_range(0, 3) == 0 ? 32'h8000_0000 : $urandom;
      y = $urandom_range(0, 3) == 0 ? 32'h7FFF_FFFF : $urandom;
      issue(4'($urandom_range(0, 15)), x, y);
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    w = 0;
    while (q.size() != 0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (q.size() != 0) chk("drain_timeout", q.size(), 32'd0);
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
